isb_stream_ctrl: RTL and testbench
==================================

ISB_STREAM_CTRL -- requirements
Module: isb_stream_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_LOG, default 2, meaning the stream buffer holds 2**DEPTH_LOG entries.
REQ-002 SHALL have parameter STREAM_LEN, default 16, meaning SAs per stream allocation (power of 2); it sets the boundary for stream termination.
REQ-003 clk  in  1  sole clock; all state changes on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 trig_v  in  1  prefetch trigger; the PS-AMC hit for the current demand access.
REQ-006 trig_sa  in  32  structural address of the triggering access.
REQ-007 sp_req_v  out  1  SP-AMC lookup request.
REQ-008 sp_req_sa  out  32  SA to translate.
REQ-009 sp_rsp_v  in  1  lookup response; arrives exactly 1 cycle after sp_req_v.
REQ-010 sp_rsp_hit  in  1  mapping present.
REQ-011 sp_rsp_pa  in  16  translated physical address.
REQ-012 pf_v  out  1  prefetch issue valid.
REQ-013 pf_addr  out  16  prefetch address.
REQ-014 pf_ready  in  1  memory accepts the prefetch.
REQ-015 demand_v  in  1  demand access valid.
REQ-016 demand_addr  in  16  demand physical address.
REQ-017 sb_hit  out  1  demand matched the stream-buffer head; combinational in the same cycle.

Function
REQ-018 FSM states SHALL be IDLE, LOOKUP, WAIT and FULL.
REQ-019 In IDLE, with no trig_v, there SHALL be no state change.
REQ-020 trig_v in any state SHALL have highest priority: flush all entries, set cur_sa <= trig_sa+1 and go to LOOKUP.
REQ-021 LOOKUP SHALL assert sp_req_v=1 with sp_req_sa=cur_sa for exactly one cycle, then go to WAIT.
REQ-022 In WAIT with sp_rsp_v && !sp_rsp_hit, the FSM SHALL go to IDLE (end of stream) and push nothing.
REQ-023 In WAIT with sp_rsp_v && sp_rsp_hit, the block SHALL push sp_rsp_pa (issued=0) and set cur_sa <= cur_sa+1.
REQ-024 After a WAIT hit, the next state SHALL be: IDLE if (cur_sa+1) mod STREAM_LEN == 0; else FULL if the buffer is then full; else LOOKUP.
REQ-025 FULL SHALL go to LOOKUP in the cycle after an entry is popped.
REQ-026 The block SHALL issue a lookup only when a free slot is guaranteed; a push never overflows.
REQ-027 sp_rsp_v outside WAIT SHALL be ignored, which covers stale responses after a trigger flush.
REQ-028 cur_sa SHALL be 32-bit and wrap modulo 2**32.
REQ-029 pf_v SHALL be 1 iff an unissued entry exists; pf_addr = the oldest unissued entry.
REQ-030 On pf_v && pf_ready, the block SHALL mark that entry issued.
REQ-031 While pf_v && !pf_ready, pf_addr SHALL stay stable unless trig_v flushes.
REQ-032 sb_hit SHALL equal demand_v && buffer non-empty && head issued && demand_addr == head PA.
REQ-033 sb_hit=1 SHALL pop the head at the next edge; a demand that does not match the head changes nothing.
REQ-034 A push and a pop in the same cycle SHALL both take effect; count is unchanged.
REQ-035 Pop, issue and push in one cycle SHALL all apply; the issued mark applies to the entry selected before the pop.
REQ-036 A trigger in the same cycle as a hit, issue or push SHALL make the flush win; sb_hit is still reported combinationally.

Reset
REQ-037 On reset=1 at posedge clk: state=IDLE, buffer empty, all issued bits 0, cur_sa=0.
REQ-038 On reset: sp_req_v=0, pf_v=0, sb_hit=0, sp_req_sa=0, pf_addr=0.
REQ-039 Reset mid-WAIT SHALL discard the pending response.
REQ-040 Reset SHALL override trig_v.

Structure
REQ-041 Shared package isb_pkg SHALL hold PA_W=16, SA_W=32, STREAM_LEN default and the FSM state enum.
REQ-042 One sub-module isb_stream_buf SHALL hold the circular buffer with head, issue and tail pointers, count, and per-entry issued bits.
REQ-043 The top level SHALL contain only the FSM and the cur_sa register.

Verification
REQ-044 trig_sa=0x20 with hits PA 0x100..0x103 -> sp_req_sa 0x21..0x24; pf_addr 0x100..0x103 in order; FSM reaches FULL after 4 pushes.
REQ-045 In FULL, demand 0x100 with head issued -> sb_hit=1 same cycle; next lookup sp_req_sa=0x25 two cycles later.
REQ-046 trig_sa=0x2D, all hits -> lookups 0x2E and 0x2F only; IDLE after 0x2F (boundary).
REQ-047 Miss on the first lookup -> IDLE, pf_v stays 0.
REQ-048 trig_v asserted during WAIT -> response ignored, buffer empty, sp_req_sa = new trig_sa+1 next cycle.
REQ-049 pf_ready=0 for 5 cycles -> pf_addr holds 0x100; demand 0x100 before issue gives sb_hit=0.

Source files
------------

// File: rtl/isb_pkg.sv
// Shared widths, defaults and FSM encoding for the ISB stream prefetch controller.
package isb_pkg;

    localparam int unsigned PA_W               = 16;
    localparam int unsigned SA_W               = 32;
    localparam int unsigned STREAM_LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WAIT,
        ST_FULL
    } isb_state_e;

    // A stream ends when the next SA would start a new STREAM_LEN-aligned allocation.
    function automatic logic sa_at_boundary(input logic [SA_W-1:0] sa, input int unsigned len);
        logic [SA_W-1:0] mask;
        mask = SA_W'(len - 1);
        return (sa & mask) == '0;
    endfunction

endpackage

// File: rtl/isb_stream_ctrl_if.sv
// Trigger, SP-AMC lookup, prefetch issue and demand signals of the stream controller.
interface isb_stream_ctrl_if;
    import isb_pkg::*;

    logic            trig_v;
    logic [SA_W-1:0] trig_sa;
    logic            sp_req_v;
    logic [SA_W-1:0] sp_req_sa;
    logic            sp_rsp_v;
    logic            sp_rsp_hit;
    logic [PA_W-1:0] sp_rsp_pa;
    logic            pf_v;
    logic [PA_W-1:0] pf_addr;
    logic            pf_ready;
    logic            demand_v;
    logic [PA_W-1:0] demand_addr;
    logic            sb_hit;

    modport slave (
        input  trig_v, trig_sa, sp_rsp_v, sp_rsp_hit, sp_rsp_pa, pf_ready,
               demand_v, demand_addr,
        output sp_req_v, sp_req_sa, pf_v, pf_addr, sb_hit
    );

    modport master (
        output trig_v, trig_sa, sp_rsp_v, sp_rsp_hit, sp_rsp_pa, pf_ready,
               demand_v, demand_addr,
        input  sp_req_v, sp_req_sa, pf_v, pf_addr, sb_hit
    );

endinterface

// File: rtl/isb_stream_buf.sv
// Circular stream buffer: entries are pushed at tail, issued in order, popped at head on a demand hit.
module isb_stream_buf
    import isb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_flush,
    input  logic            i_push,
    input  logic [PA_W-1:0] i_push_pa,
    input  logic            i_pf_ready,
    input  logic            i_demand_v,
    input  logic [PA_W-1:0] i_demand_addr,
    output logic            o_pf_v,
    output logic [PA_W-1:0] o_pf_addr,
    output logic            o_sb_hit,
    output logic            o_full,
    output logic            o_one_free
);

    localparam int unsigned      DEPTH    = 2 ** DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] CNT_FULL = (DEPTH_LOG + 1)'(DEPTH);
    localparam logic [DEPTH_LOG:0] CNT_LAST = (DEPTH_LOG + 1)'(DEPTH - 1);

    logic [PA_W-1:0]      r_pa [DEPTH];
    logic [DEPTH-1:0]     r_iss;
    logic [DEPTH_LOG-1:0] r_head;
    logic [DEPTH_LOG-1:0] r_issp;
    logic [DEPTH_LOG-1:0] r_tail;
    logic [DEPTH_LOG:0]   r_count;
    logic [DEPTH_LOG:0]   r_unissued;

    logic w_pop;
    logic w_issue;

    assign o_sb_hit   = i_demand_v && (r_count != '0) && r_iss[r_head] &&
                        (i_demand_addr == r_pa[r_head]);
    assign o_pf_v     = (r_unissued != '0);
    assign o_pf_addr  = o_pf_v ? r_pa[r_issp] : '0;
    assign o_full     = (r_count == CNT_FULL);
    assign o_one_free = (r_count == CNT_LAST);

    assign w_pop   = o_sb_hit;
    assign w_issue = o_pf_v && i_pf_ready;

    // Issue and push never address the same slot: issue targets a held entry, push a free one.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_iss      <= '0;
            r_head     <= '0;
            r_issp     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_unissued <= '0;
        end else begin
            if (w_issue) begin
                r_iss[r_issp] <= 1'b1;
                r_issp        <= r_issp + DEPTH_LOG'(1);
            end
            if (i_push) begin
                r_iss[r_tail] <= 1'b0;
                r_pa[r_tail]  <= i_push_pa;
                r_tail        <= r_tail + DEPTH_LOG'(1);
            end
            if (w_pop) begin
                r_head <= r_head + DEPTH_LOG'(1);
            end
            r_count    <= r_count + (DEPTH_LOG + 1)'(i_push) - (DEPTH_LOG + 1)'(w_pop);
            r_unissued <= r_unissued + (DEPTH_LOG + 1)'(i_push) - (DEPTH_LOG + 1)'(w_issue);
        end
    end

endmodule

// File: rtl/isb_stream_ctrl.sv
// Stream prefetch controller: walks SAs from a trigger, translates via SP-AMC, queues PAs for prefetch.
module isb_stream_ctrl
    import isb_pkg::*;
#(
    parameter int unsigned DEPTH_LOG  = 2,
    parameter int unsigned STREAM_LEN = STREAM_LEN_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    isb_stream_ctrl_if.slave bus
);

    isb_state_e      r_state;
    isb_state_e      w_state_nxt;
    logic [SA_W-1:0] r_cur_sa;
    logic [SA_W-1:0] w_cur_sa_nxt;
    logic [SA_W-1:0] w_sa_inc;
    logic            w_push;
    logic            w_flush;
    logic            w_req_v;
    logic            w_pf_v;
    logic [PA_W-1:0] w_pf_addr;
    logic            w_sb_hit;
    logic            w_full;
    logic            w_one_free;

    isb_stream_buf #(
        .DEPTH_LOG(DEPTH_LOG)
    ) u_buf (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (w_flush),
        .i_push       (w_push),
        .i_push_pa    (bus.sp_rsp_pa),
        .i_pf_ready   (bus.pf_ready),
        .i_demand_v   (bus.demand_v),
        .i_demand_addr(bus.demand_addr),
        .o_pf_v       (w_pf_v),
        .o_pf_addr    (w_pf_addr),
        .o_sb_hit     (w_sb_hit),
        .o_full       (w_full),
        .o_one_free   (w_one_free)
    );

    assign w_sa_inc      = r_cur_sa + SA_W'(1);
    assign w_req_v       = (r_state == ST_LOOKUP);
    assign bus.sp_req_v  = w_req_v;
    assign bus.sp_req_sa = w_req_v ? r_cur_sa : '0;
    assign bus.pf_v      = w_pf_v;
    assign bus.pf_addr   = w_pf_addr;
    assign bus.sb_hit    = w_sb_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cur_sa <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cur_sa <= w_cur_sa_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cur_sa_nxt = r_cur_sa;
        w_push       = 1'b0;
        w_flush      = 1'b0;
        if (bus.trig_v) begin
            w_flush      = 1'b1;
            w_cur_sa_nxt = bus.trig_sa + SA_W'(1);
            w_state_nxt  = ST_LOOKUP;
        end else begin
            case (r_state)
                ST_LOOKUP: w_state_nxt = ST_WAIT;
                ST_WAIT: begin
                    if (bus.sp_rsp_v) begin
                        if (bus.sp_rsp_hit) begin
                            w_push       = 1'b1;
                            w_cur_sa_nxt = w_sa_inc;
                            // A same-cycle pop keeps the count, so only a push into the last slot fills it.
                            if (sa_at_boundary(w_sa_inc, STREAM_LEN)) begin
                                w_state_nxt = ST_IDLE;
                            end else if (w_one_free && !w_sb_hit) begin
                                w_state_nxt = ST_FULL;
                            end else begin
                                w_state_nxt = ST_LOOKUP;
                            end
                        end else begin
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_FULL: begin
                    if (!w_full) begin
                        w_state_nxt = ST_LOOKUP;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

endmodule

// File: tb/tb_isb_stream_ctrl.sv
// Directed bench for isb_stream_ctrl: inputs change and outputs are sampled around the falling edge.
module tb_isb_stream_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    isb_stream_ctrl_if bus();

    isb_stream_ctrl #(
        .DEPTH_LOG (2),
        .STREAM_LEN(16)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clr();
        bus.trig_v     = 1'b0;
        bus.sp_rsp_v   = 1'b0;
        bus.sp_rsp_hit = 1'b0;
        bus.demand_v   = 1'b0;
    endtask

    task automatic next_cyc();
        @(negedge clk);
        clr();
    endtask

    task automatic trig(input logic [31:0] sa);
        bus.trig_v  = 1'b1;
        bus.trig_sa = sa;
    endtask

    task automatic rsp(input logic hit, input logic [15:0] pa);
        bus.sp_rsp_v   = 1'b1;
        bus.sp_rsp_hit = hit;
        bus.sp_rsp_pa  = pa;
    endtask

    task automatic dem(input logic [15:0] addr);
        bus.demand_v    = 1'b1;
        bus.demand_addr = addr;
    endtask

    initial begin
        reset = 1'b1;
        bus.pf_ready = 1'b1;
        bus.trig_sa = '0;
        bus.sp_rsp_pa = '0;
        bus.demand_addr = '0;
        clr();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_req_v", 32'(bus.sp_req_v), 32'd0);
        chk("rst_req_sa", bus.sp_req_sa, 32'd0);
        chk("rst_pf_v", 32'(bus.pf_v), 32'd0);
        chk("rst_pf_addr", 32'(bus.pf_addr), 32'd0);
        chk("rst_sb_hit", 32'(bus.sb_hit), 32'd0);

        // Fill the buffer from SA 0x21 onwards until FULL.
        next_cyc(); trig(32'h20);
        for (int i = 0; i < 4; i++) begin
            next_cyc(); #1;
            chk("s1_req_v", 32'(bus.sp_req_v), 32'd1);
            chk("s1_req_sa", bus.sp_req_sa, 32'h21 + i);
            chk("s1_pf_v", 32'(bus.pf_v), (i > 0) ? 32'd1 : 32'd0);
            if (i > 0) chk("s1_pf_addr", 32'(bus.pf_addr), 32'h100 + i - 1);
            next_cyc(); rsp(1'b1, 16'(32'h100 + i)); #1;
            chk("s1_wait_req_v", 32'(bus.sp_req_v), 32'd0);
        end
        next_cyc(); #1;
        chk("s1_full_req_v", 32'(bus.sp_req_v), 32'd0);
        chk("s1_full_pf_v", 32'(bus.pf_v), 32'd1);
        chk("s1_full_pf_addr", 32'(bus.pf_addr), 32'h103);
        next_cyc(); #1;
        chk("s1_full_hold_req_v", 32'(bus.sp_req_v), 32'd0);
        chk("s1_full_hold_pf_v", 32'(bus.pf_v), 32'd0);
        next_cyc(); dem(16'h100); #1;
        chk("s1_head_hit", 32'(bus.sb_hit), 32'd1);
        next_cyc(); dem(16'h102); #1;
        chk("s1_nonhead_miss", 32'(bus.sb_hit), 32'd0);
        chk("s1_gap_req_v", 32'(bus.sp_req_v), 32'd0);
        next_cyc(); #1;
        chk("s1_relookup_v", 32'(bus.sp_req_v), 32'd1);
        chk("s1_relookup_sa", bus.sp_req_sa, 32'h25);
        next_cyc(); rsp(1'b0, 16'h0);

        // Stream boundary: 0x2E and 0x2F only.
        next_cyc(); trig(32'h2D);
        next_cyc(); #1;
        chk("s2_sa0", bus.sp_req_sa, 32'h2E);
        chk("s2_flushed_pf_v", 32'(bus.pf_v), 32'd0);
        next_cyc(); rsp(1'b1, 16'h200);
        next_cyc(); #1;
        chk("s2_sa1", bus.sp_req_sa, 32'h2F);
        chk("s2_pf_addr0", 32'(bus.pf_addr), 32'h200);
        next_cyc(); rsp(1'b1, 16'h201);
        next_cyc(); #1;
        chk("s2_end_req_v", 32'(bus.sp_req_v), 32'd0);
        chk("s2_pf_addr1", 32'(bus.pf_addr), 32'h201);
        next_cyc(); #1;
        chk("s2_idle_req_v", 32'(bus.sp_req_v), 32'd0);

        // First lookup misses.
        next_cyc(); trig(32'h40);
        next_cyc(); #1;
        chk("s3_sa", bus.sp_req_sa, 32'h41);
        next_cyc(); rsp(1'b0, 16'h0);
        next_cyc(); #1;
        chk("s3_req_v", 32'(bus.sp_req_v), 32'd0);
        chk("s3_pf_v", 32'(bus.pf_v), 32'd0);

        // Trigger during WAIT beats the response; stale response in LOOKUP is dropped.
        next_cyc(); trig(32'h50);
        next_cyc(); #1;
        chk("s4_sa", bus.sp_req_sa, 32'h51);
        next_cyc(); trig(32'h60); rsp(1'b1, 16'h300);
        next_cyc(); #1;
        chk("s4_retrig_sa", bus.sp_req_sa, 32'h61);
        chk("s4_flush_pf_v", 32'(bus.pf_v), 32'd0);
        next_cyc(); rsp(1'b1, 16'h310);
        next_cyc(); rsp(1'b1, 16'h399); #1;
        chk("s4_sa2", bus.sp_req_sa, 32'h62);
        chk("s4_pf_addr", 32'(bus.pf_addr), 32'h310);
        next_cyc(); rsp(1'b0, 16'h0);
        next_cyc(); #1;
        chk("s4_stale_pf_v", 32'(bus.pf_v), 32'd0);

        // Back-pressure on prefetch issue.
        next_cyc(); trig(32'h80); bus.pf_ready = 1'b0;
        next_cyc(); #1;
        chk("s5_sa", bus.sp_req_sa, 32'h81);
        next_cyc(); rsp(1'b1, 16'h100);
        next_cyc(); #1;
        chk("s5_hold_lookup", 32'(bus.pf_addr), 32'h100);
        next_cyc(); rsp(1'b0, 16'h0); #1;
        chk("s5_hold_wait", 32'(bus.pf_addr), 32'h100);
        for (int k = 0; k < 3; k++) begin
            next_cyc(); dem(16'h100); #1;
            chk("s5_hold_pf_v", 32'(bus.pf_v), 32'd1);
            chk("s5_hold_addr", 32'(bus.pf_addr), 32'h100);
            chk("s5_unissued_hit", 32'(bus.sb_hit), 32'd0);
        end
        next_cyc(); bus.pf_ready = 1'b1; #1;
        chk("s5_issue_addr", 32'(bus.pf_addr), 32'h100);
        next_cyc(); dem(16'h100); #1;
        chk("s5_issued_pf_v", 32'(bus.pf_v), 32'd0);
        chk("s5_issued_hit", 32'(bus.sb_hit), 32'd1);
        next_cyc(); dem(16'h100); #1;
        chk("s5_popped_hit", 32'(bus.sb_hit), 32'd0);

        // Pop, issue and push in one cycle; then trigger colliding with a hit; then reset mid-WAIT.
        next_cyc(); trig(32'hA0);
        next_cyc(); #1;
        chk("s6_sa0", bus.sp_req_sa, 32'hA1);
        next_cyc(); rsp(1'b1, 16'h400);
        next_cyc(); #1;
        chk("s6_sa1", bus.sp_req_sa, 32'hA2);
        chk("s6_pf0", 32'(bus.pf_addr), 32'h400);
        next_cyc(); rsp(1'b1, 16'h401); bus.pf_ready = 1'b0;
        next_cyc(); #1;
        chk("s6_sa2", bus.sp_req_sa, 32'hA3);
        chk("s6_pf1", 32'(bus.pf_addr), 32'h401);
        next_cyc(); rsp(1'b1, 16'h402); dem(16'h400); bus.pf_ready = 1'b1; #1;
        chk("s6_triple_hit", 32'(bus.sb_hit), 32'd1);
        next_cyc(); dem(16'h401); #1;
        chk("s6_sa3", bus.sp_req_sa, 32'hA4);
        chk("s6_pf2", 32'(bus.pf_addr), 32'h402);
        chk("s6_second_hit", 32'(bus.sb_hit), 32'd1);
        next_cyc(); rsp(1'b0, 16'h0);
        next_cyc(); dem(16'h402); trig(32'hB0); #1;
        chk("s6_trig_hit", 32'(bus.sb_hit), 32'd1);
        next_cyc(); dem(16'h402); #1;
        chk("s6_trig_sa", bus.sp_req_sa, 32'hB1);
        chk("s6_flushed_hit", 32'(bus.sb_hit), 32'd0);
        next_cyc(); reset = 1'b1; trig(32'hC0); rsp(1'b1, 16'h500);
        next_cyc(); reset = 1'b0; dem(16'h500); #1;
        chk("s6_rst_req_v", 32'(bus.sp_req_v), 32'd0);
        chk("s6_rst_req_sa", bus.sp_req_sa, 32'd0);
        chk("s6_rst_pf_v", 32'(bus.pf_v), 32'd0);
        chk("s6_rst_pf_addr", 32'(bus.pf_addr), 32'd0);
        chk("s6_rst_hit", 32'(bus.sb_hit), 32'd0);
        next_cyc(); #1;
        chk("s6_rst_idle", 32'(bus.sp_req_v), 32'd0);

        // cur_sa wraps modulo 2**32.
        next_cyc(); trig(32'hFFFF_FFFF);
        next_cyc(); #1;
        chk("wrap_req_v", 32'(bus.sp_req_v), 32'd1);
        chk("wrap_req_sa", bus.sp_req_sa, 32'h0);
        next_cyc(); rsp(1'b0, 16'h0);
        next_cyc(); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
